riscv_mem_arb: RTL and testbench

RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

---
 rtl/riscv_mem_arb.sv | 142 ++++++++++++++
 tb/tb_riscv_mem_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arb.sv
// Two-requester (fetch / load-store) arbiter onto one memory bus port, MEM has priority.
// Define MEM_ARB_STARVE_EN to force an IF grant after three MEM grants taken while IF waited.
module riscv_mem_arb (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IF_req_i,
  input  logic [31:0] IF_addr_i,
  output logic [31:0] IF_rdata_o,
  output logic        IF_ack_o,
  input  logic        IF_flush_i,
  output logic        IF_stall_o,
  input  logic        MEM_req_i,
  input  logic        MEM_we_i,
  input  logic [3:0]  MEM_be_i,
  input  logic [31:0] MEM_addr_i,
  input  logic [31:0] MEM_wdata_i,
  output logic [31:0] MEM_rdata_o,
  output logic        MEM_ack_o,
  output logic        MEM_stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        if_first;

`ifdef MEM_ARB_STARVE_EN
  logic [1:0]  starve_cnt_q, starve_cnt_d;
  assign if_first = (starve_cnt_q == 2'd3);
`else
  assign if_first = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
`ifdef MEM_ARB_STARVE_EN
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (MEM_req_i && !(IF_req_i && if_first)) begin
          state_d     = GNT_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = MEM_we_i;
          bus_be_d    = MEM_be_i;
          bus_addr_d  = MEM_addr_i;
          bus_wdata_d = MEM_wdata_i;
`ifdef MEM_ARB_STARVE_EN
          if (IF_req_i) starve_cnt_d = starve_cnt_q + 2'd1;
`endif
        end else if (IF_req_i) begin
          state_d     = GNT_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_be_d    = 4'hF;
          bus_addr_d  = IF_addr_i;
          bus_wdata_d = 32'd0;
`ifdef MEM_ARB_STARVE_EN
          starve_cnt_d = 2'd0;
`endif
        end
      end
      GNT_IF: begin
        // The ack retires the dropped fetch, so it wins over a new flush.
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          drop_d    = 1'b0;
        end else if (IF_flush_i) begin
          drop_d = 1'b1;
        end
      end
      GNT_MEM: begin
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'h0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt_q <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_be_o    = bus_be_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

  // A flush in the ack cycle must also hide that ack, hence the direct IF_flush_i term.
  assign IF_ack_o    = !rst_i && bus_ack_i && (state_q == GNT_IF) && !drop_q && !IF_flush_i;
  assign MEM_ack_o   = !rst_i && bus_ack_i && (state_q == GNT_MEM);
  assign IF_rdata_o  = bus_rdata_i;
  assign MEM_rdata_o = bus_rdata_i;
  assign IF_stall_o  = IF_req_i && !IF_ack_o;
  assign MEM_stall_o = MEM_req_i && !MEM_ack_o;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb; expected bus transactions queue up as requests are driven.
module tb_riscv_mem_arb;

`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        IF_req_i, IF_flush_i;
  logic [31:0] IF_addr_i;
  logic [31:0] IF_rdata_o;
  logic        IF_ack_o, IF_stall_o;
  logic        MEM_req_i, MEM_we_i;
  logic [3:0]  MEM_be_i;
  logic [31:0] MEM_addr_i, MEM_wdata_i;
  logic [31:0] MEM_rdata_o;
  logic        MEM_ack_o, MEM_stall_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  txn_t last;
  int   total = 0;
  int   bad   = 0;

  riscv_mem_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IF_req_i(IF_req_i), .IF_addr_i(IF_addr_i), .IF_rdata_o(IF_rdata_o),
    .IF_ack_o(IF_ack_o), .IF_flush_i(IF_flush_i), .IF_stall_o(IF_stall_o),
    .MEM_req_i(MEM_req_i), .MEM_we_i(MEM_we_i), .MEM_be_i(MEM_be_i),
    .MEM_addr_i(MEM_addr_i), .MEM_wdata_i(MEM_wdata_i), .MEM_rdata_o(MEM_rdata_o),
    .MEM_ack_o(MEM_ack_o), .MEM_stall_o(MEM_stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.be = b; t.wdata = d;
    sb.push_back(t);
  endtask

  task automatic check_bus(input string tag, input txn_t t);
    check({tag, "_req"},   {31'd0, bus_req_o}, 32'd1);
    check({tag, "_addr"},  bus_addr_o, t.addr);
    check({tag, "_we"},    {31'd0, bus_we_o}, {31'd0, t.we});
    check({tag, "_be"},    {28'd0, bus_be_o}, {28'd0, t.be});
    check({tag, "_wdata"}, bus_wdata_o, t.wdata);
  endtask

  // Waits for the grant, checks it against the queue head, holds for lat cycles, then acks.
  task automatic serve(input string tag, input int lat, input logic [31:0] rdata,
                       input bit exp_if, input bit exp_mem,
                       input bit drop_if, input bit drop_mem, input int flush_at);
    txn_t t;
    int   n = 0;
    @(negedge clk_i); #1;
    while (bus_req_o !== 1'b1 && n < 20) begin
      @(negedge clk_i); #1;
      n++;
    end
    check({tag, "_grant"}, {31'd0, bus_req_o}, 32'd1);
    if (bus_req_o !== 1'b1 || sb.size() == 0) return;
    t = sb.pop_front();
    last = t;
    IF_flush_i = (flush_at == 0);
    check_bus({tag, "_g"}, t);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk_i);
      IF_flush_i = (flush_at == i);
      #1;
      check_bus({tag, "_hold"}, t);
      check({tag, "_hold_ifack"},  {31'd0, IF_ack_o}, 32'd0);
      check({tag, "_hold_memack"}, {31'd0, MEM_ack_o}, 32'd0);
      check({tag, "_hold_ifstall"},  {31'd0, IF_stall_o},  {31'd0, IF_req_i});
      check({tag, "_hold_memstall"}, {31'd0, MEM_stall_o}, {31'd0, MEM_req_i});
    end
    @(negedge clk_i);
    IF_flush_i  = (flush_at == lat);
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    #1;
    check_bus({tag, "_ackcyc"}, t);
    check({tag, "_ifack"},  {31'd0, IF_ack_o},  {31'd0, exp_if});
    check({tag, "_memack"}, {31'd0, MEM_ack_o}, {31'd0, exp_mem});
    if (exp_if)  check({tag, "_ifrdata"},  IF_rdata_o,  rdata);
    if (exp_mem) check({tag, "_memrdata"}, MEM_rdata_o, rdata);
    check({tag, "_ifstall"},  {31'd0, IF_stall_o},  {31'd0, IF_req_i && !exp_if});
    check({tag, "_memstall"}, {31'd0, MEM_stall_o}, {31'd0, MEM_req_i && !exp_mem});
    @(negedge clk_i);
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'd0;
    IF_flush_i  = 1'b0;
    if (drop_if)  IF_req_i  = 1'b0;
    if (drop_mem) MEM_req_i = 1'b0;
    #1;
    check({tag, "_idle_req"}, {31'd0, bus_req_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    IF_req_i = 1'b0; IF_addr_i = 32'd0; IF_flush_i = 1'b0;
    MEM_req_i = 1'b0; MEM_we_i = 1'b0; MEM_be_i = 4'h0; MEM_addr_i = 32'd0; MEM_wdata_i = 32'd0;
    bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_req",   {31'd0, bus_req_o}, 32'd0);
    check("rst_we",    {31'd0, bus_we_o}, 32'd0);
    check("rst_be",    {28'd0, bus_be_o}, 32'd0);
    check("rst_addr",  bus_addr_o, 32'd0);
    check("rst_wdata", bus_wdata_o, 32'd0);
    check("rst_acks",  {30'd0, IF_ack_o, MEM_ack_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Plain fetch, two-cycle bus latency.
    @(negedge clk_i);
    IF_req_i = 1'b1; IF_addr_i = 32'h100;
    push(32'h100, 1'b0, 4'hF, 32'd0);
    #1;
    check("f1_stall_pre", {31'd0, IF_stall_o}, 32'd1);
    check("f1_req_pre",   {31'd0, bus_req_o}, 32'd0);
    serve("f1", 2, 32'h00500093, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    $display("txn fetch 0x100 done");

    // Simultaneous requests: store wins, fetch follows after one idle cycle.
    @(negedge clk_i);
    MEM_req_i = 1'b1; MEM_we_i = 1'b1; MEM_be_i = 4'b0011;
    MEM_addr_i = 32'h2000; MEM_wdata_i = 32'hDEADBEEF;
    IF_req_i = 1'b1; IF_addr_i = 32'h1000;
    push(32'h2000, 1'b1, 4'b0011, 32'hDEADBEEF);
    push(32'h1000, 1'b0, 4'hF, 32'd0);
    serve("st", 1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    check("st_if_wait", {31'd0, IF_stall_o}, 32'd1);
    serve("f2", 2, 32'h13, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    $display("txn store 0x2000 then fetch 0x1000 done");

    // Flush mid-fetch: ack hidden.
    @(negedge clk_i);
    IF_req_i = 1'b1; IF_addr_i = 32'h300;
    push(32'h300, 1'b0, 4'hF, 32'd0);
    serve("fl1", 3, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    $display("txn flushed fetch 0x300 done");

    // Flush coincident with the ack: ack hidden.
    @(negedge clk_i);
    IF_req_i = 1'b1; IF_addr_i = 32'h240;
    push(32'h240, 1'b0, 4'hF, 32'd0);
    serve("fl2", 1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    $display("txn flush-at-ack fetch 0x240 done");

    // Flush while idle is harmless; this fetch completes.
    @(negedge clk_i);
    IF_req_i = 1'b1; IF_addr_i = 32'h200; IF_flush_i = 1'b1;
    push(32'h200, 1'b0, 4'hF, 32'd0);
    serve("f3", 1, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    $display("txn fetch 0x200 done");

    // Reset while a load waits for its ack.
    @(negedge clk_i);
    MEM_req_i = 1'b1; MEM_we_i = 1'b0; MEM_be_i = 4'hF; MEM_addr_i = 32'h3000; MEM_wdata_i = 32'd0;
    push(32'h3000, 1'b0, 4'hF, 32'd0);
    @(negedge clk_i); #1;
    if (sb.size() != 0) last = sb.pop_front();
    check_bus("rs_g", last);
    rst_i = 1'b1; MEM_req_i = 1'b0;
    #1;
    check("rs_req",   {31'd0, bus_req_o}, 32'd0);
    check("rs_addr",  bus_addr_o, 32'd0);
    check("rs_bewe",  {27'd0, bus_be_o, bus_we_o}, 32'd0);
    @(negedge clk_i);
    bus_ack_i = 1'b1;
    #1;
    check("rs_ack_in_rst", {30'd0, IF_ack_o, MEM_ack_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rs_ack_after", {30'd0, IF_ack_o, MEM_ack_o}, 32'd0);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1;
    check("rs_idle_req", {31'd0, bus_req_o}, 32'd0);
    $display("txn reset mid-load done");

    // Both requesters held continuously.
    @(negedge clk_i);
    MEM_req_i = 1'b1; MEM_we_i = 1'b0; MEM_be_i = 4'hF; MEM_addr_i = 32'h500; MEM_wdata_i = 32'd0;
    IF_req_i = 1'b1; IF_addr_i = 32'h400;
    for (int i = 0; i < 5; i++) begin
      if (STARVE && i == 3) push(32'h400, 1'b0, 4'hF, 32'd0);
      else                  push(32'h500, 1'b0, 4'hF, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      bit is_if;
      is_if = STARVE && (i == 3);
      serve("sv", 1, 32'hA0 + i, is_if, !is_if, i == 4, i == 4, -1);
      $display("txn held-requests grant %0d to %s", i, is_if ? "IF" : "MEM");
    end

    // Spurious ack while idle.
    @(negedge clk_i);
    bus_ack_i = 1'b1;
    #1;
    check("sp_acks", {30'd0, IF_ack_o, MEM_ack_o}, 32'd0);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1;
    check("sp_req",   {31'd0, bus_req_o}, 32'd0);
    check("sp_addr",  bus_addr_o, last.addr);
    check("sp_be",    {28'd0, bus_be_o}, {28'd0, last.be});
    check("sp_we",    {31'd0, bus_we_o}, {31'd0, last.we});
    IF_req_i = 1'b1; IF_addr_i = 32'h600;
    push(32'h600, 1'b0, 4'hF, 32'd0);
    serve("f4", 2, 32'h44444444, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    $display("txn spurious ack then fetch 0x600 done");

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
